// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch controller for the RISC-V IF stage: sequential
// increment, stall, redirect, trap vectoring, halt and an imem req/ack handshake.
module pc_fetch_ctrl #(
  parameter int unsigned         PC_W     = 10,
  parameter logic [PC_W-1:0]     RESET_PC = '0,
  parameter logic [PC_W-1:0]     TRAP_PC  = 10'h3F0,
  parameter int unsigned         INC      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            trap,
  input  logic            fetch_ack,
  output logic            fetch_req,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus,
  output logic            flush,
  output logic            misalign,
  output logic            halted
);

  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, HALTED = 2'd2} state_e;

  // Low address bits that must be zero for a target to be INC-aligned.
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(INC - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;
  logic            tgt_misaligned;

  assign pc_plus        = pc_q + PC_W'(INC);
  assign tgt_misaligned = |(redirect_pc & ALIGN_MASK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  // Trap and redirect act in every state; the rest only matter in FETCH.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    if (trap) begin
      pc_d    = TRAP_PC;
      flush_d = 1'b1;
      state_d = FETCH;
    end else if (redirect_valid && tgt_misaligned) begin
      pc_d       = TRAP_PC;
      flush_d    = 1'b1;
      misalign_d = 1'b1;
      state_d    = FETCH;
    end else if (redirect_valid) begin
      pc_d    = redirect_pc;
      flush_d = 1'b1;
      state_d = FETCH;
    end else begin
      case (state_q)
        BOOT:  state_d = FETCH;
        FETCH: begin
          if (halt)                      state_d = HALTED;
          else if (!stall && fetch_ack)  pc_d    = pc_plus;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    fetch_req = (state_q == FETCH) && !stall;
    halted    = (state_q == HALTED);
  end

  assign pc       = pc_q;
  assign flush    = flush_q;
  assign misalign = misalign_q;

endmodule
